pixel_window_gen: RTL and testbench
===================================

Name: pixel_window_gen

Overview:
Streaming 3x3 neighbourhood generator directly upstream of the sobel stage. Accepts one 8-bit grayscale pixel per handshake in raster order from the image source. Uses two line buffers and a 3x3 shift window to present every interior 3x3 window with its centre coordinates. Replaces whole-frame bus transfer into sobel with a pixel stream.

Parameters:
WIDTH, 640, image width in pixels (min 3)
DEPTH, 480, image height in lines (min 3)
XW, clog2(WIDTH), column counter / coordinate width
YW, clog2(DEPTH), row counter / coordinate width

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
pix_in  input  8  grayscale pixel, raster order, (0,0) first
pix_valid  input  1  pix_in valid
pix_ready  output  1  block can accept pix_in this cycle
win_out  output  72  3x3 window; byte index 3*r+c at [8*(3*r+c)+:8]; r=0 top line, c=0 left column
win_x  output  XW  window centre column
win_y  output  YW  window centre row
win_valid  output  1  win_out/win_x/win_y valid
win_ready  input  1  downstream consumes window this cycle
frame_done  output  1  one-cycle pulse after last pixel of frame accepted

Behaviour:
- Reset: asynchronous on rst_n low. Column counter, row counter, win_valid, frame_done, win_x, win_y, win_out all cleared to 0. Line buffer RAM contents are not cleared; never observable (see emission rule).
- Accept: pixel accepted on a rising edge when pix_valid && pix_ready. pix_ready = !win_valid || win_ready (single output register, combinational ready, no bubble at full throughput).
- Counters (col x, row y): on accept x increments. At x==WIDTH-1, x wraps to 0 and y increments. At y==DEPTH-1 with x==WIDTH-1, both wrap to 0 and frame_done pulses high the following cycle.
- Line buffers: lb1 holds line y-1, lb0 holds line y-2, addressed by x. Read-before-write. On accept: lb0[x] <= lb1[x], lb1[x] <= pix_in.
- Shift window: on accept, each row shifts left by one column. New right column = {lb0[x], lb1[x], pix_in} for rows r=0,1,2.
- Emission: a window is emitted only when the accepted pixel has x>=2 and y>=2. Window centre = (x-1, y-1), so only interior centres 1..WIDTH-2 x 1..DEPTH-2 are produced. There are (WIDTH-2)*(DEPTH-2) windows per frame. No border padding.
- Latency: win_valid rises the cycle after the triggering accept. win_out, win_x and win_y are registered together with it.
- Hold: while win_valid && !win_ready, win_out/win_x/win_y are stable and pix_ready=0.
- Clear: win_valid clears on win_ready unless a new emitting accept occurs in the same cycle, in which case it stays high with new data.
- Idle: accepts without emission (x<2 or y<2) leave win_valid unchanged apart from the clear rule.
- Frame continuity: the next frame starts immediately after the last accept. Stale line-buffer data is never emitted because rows 0-1 produce no windows.
- Reset mid-frame: all of the above is aborted and counters restart at (0,0). No partial window or frame_done is produced.
- pix_valid low: no state change except the output handshake.

Decomposition:
- Shared package edge_pkg: PIX_W=8, WIN_W=9*PIX_W, window byte index constants (CENTRE=4), clog2 function.
- One sub-module, line_buffer: WIDTH x 8 single-port register array with synchronous write and read-before-write.
- pixel_window_gen instantiates two line_buffer instances.

Test Plan:
- WIDTH=4, DEPTH=4, pix=16*y+x, win_ready=1, pix_valid=1 continuous:
  - Accept of (2,2) is followed next cycle by win_valid=1, win_x=1, win_y=1.
  - win_out bytes 0..8 = 00,01,02,10,11,12,20,21,22.
  - Exactly 4 windows per frame, with centres (1,1),(2,1),(1,2),(2,2).
- Same stream; frame_done is high for exactly one cycle, the cycle after (3,3) is accepted. A second frame produces an identical window sequence with no stale data.
- Backpressure: hold win_ready=0 for 5 cycles at the first window. pix_ready=0 throughout, and win_out/win_x/win_y do not change. On win_ready=1 the next window follows the resumed input with no loss or duplication.
- Random pix_valid gaps and random win_ready on a 6x5 image: the window sequence matches a software 3x3 reference model exactly, with 12 windows.
- Assert rst_n=0 asynchronously mid-row 2 (between clock edges). Outputs go to 0 immediately. After release, a full 4x4 frame yields exactly the windows of the first test.
- Minimum size WIDTH=3, DEPTH=3: one window only, centre (1,1), bytes equal to the nine input pixels in order. frame_done follows the 9th accept.

Source files
------------

// File: rtl/edge_pkg.sv
// Shared types and constants for the edge-detection pixel pipeline.
// Window bytes are numbered 3*row+col, row 0 being the oldest (top) line.
package edge_pkg;

  localparam int PIX_W = 8;
  localparam int WIN_W = 9 * PIX_W;

  localparam int WIN_TL = 0;
  localparam int CENTRE = 4;
  localparam int WIN_BR = 8;

  typedef logic [PIX_W-1:0] pix_t;

  // Bits needed to count 0..n-1; constant-evaluable for parameter defaults.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  function automatic int win_byte(input int row, input int col);
    return 3 * row + col;
  endfunction

endpackage

// File: rtl/line_buffer.sv
// One image line of pixels: combinational read of the old value, write on the
// rising edge, so a read and write to the same address see the previous line.
module line_buffer
  import edge_pkg::*;
#(
  parameter int WIDTH = 640,
  parameter int AW    = clog2(WIDTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [7:0]    wdata,
  output logic [7:0]    rdata
);

  pix_t mem [WIDTH];

  assign rdata = mem[addr];

  // NOTE: storage has no reset; stale contents are never emitted because the
  // first two lines of every frame produce no windows.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

endmodule

// File: rtl/pixel_window_gen.sv
// Streaming 3x3 neighbourhood generator: raster pixels in, one registered
// interior window (with centre coordinates) out per accepted pixel at x,y >= 2.
module pixel_window_gen
  import edge_pkg::*;
#(
  parameter int WIDTH = 640,
  parameter int DEPTH = 480,
  parameter int XW    = clog2(WIDTH),
  parameter int YW    = clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [7:0]    pix_in,
  input  logic          pix_valid,
  output logic          pix_ready,
  output logic [71:0]   win_out,
  output logic [XW-1:0] win_x,
  output logic [YW-1:0] win_y,
  output logic          win_valid,
  input  logic          win_ready,
  output logic          frame_done
);

  localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(DEPTH - 1);

  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic          accept;
  logic          emit;
  logic          x_last;
  logic          y_last;
  pix_t          lb0_q;
  pix_t          lb1_q;
  pix_t          win_q [3][3];
  pix_t          win_d [3][3];
  logic [WIN_W-1:0] win_flat;

  // Single output register: a new pixel may enter whenever the held window
  // leaves in the same cycle.
  assign pix_ready = !win_valid || win_ready;
  assign accept    = pix_valid && pix_ready;
  assign x_last    = (x == X_LAST);
  assign y_last    = (y == Y_LAST);
  assign emit      = accept && (x >= XW'(2)) && (y >= YW'(2));

  line_buffer #(.WIDTH(WIDTH), .AW(XW)) u_lb1 (
    .clk   (clk),
    .we    (accept),
    .addr  (x),
    .wdata (pix_in),
    .rdata (lb1_q)
  );

  line_buffer #(.WIDTH(WIDTH), .AW(XW)) u_lb0 (
    .clk   (clk),
    .we    (accept),
    .addr  (x),
    .wdata (lb1_q),
    .rdata (lb0_q)
  );

  // NOTE: every always_comb output gets a value on every path (defaults or
  // full assignment) so no latches are inferred.
  always_comb begin
    for (int r = 0; r < 3; r++) begin
      win_d[r][0] = win_q[r][1];
      win_d[r][1] = win_q[r][2];
    end
    win_d[0][2] = lb0_q;
    win_d[1][2] = lb1_q;
    win_d[2][2] = pix_in;
  end

  always_comb begin
    win_flat = '0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        win_flat[PIX_W*win_byte(r, c) +: PIX_W] = win_d[r][c];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update from the same pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x          <= '0;
      y          <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= accept && x_last && y_last;
      if (accept) begin
        if (x_last) begin
          x <= '0;
          y <= y_last ? '0 : y + YW'(1);
        end else begin
          x <= x + XW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          win_q[r][c] <= '0;
        end
      end
    end else if (accept) begin
      win_q <= win_d;
    end
  end

  // Centre of the window is one column and one row behind the newest pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_valid <= 1'b0;
      win_out   <= '0;
      win_x     <= '0;
      win_y     <= '0;
    end else if (emit) begin
      win_valid <= 1'b1;
      win_out   <= win_flat;
      win_x     <= x - XW'(1);
      win_y     <= y - YW'(1);
    end else if (win_ready) begin
      win_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pixel_window_gen.sv
// Bench for pixel_window_gen: three sizes (4x4, 6x5, 3x3) driven one at a time,
// expected windows pushed to a scoreboard on accept and popped on handshake.
module tb_pixel_window_gen;
  import edge_pkg::*;

  typedef struct {
    logic [71:0] w;
    int          x;
    int          y;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pv [3];
  logic [7:0]  pi [3];
  logic        wr [3];
  logic        pr [3];
  logic        wv [3];
  logic        fd [3];
  logic [71:0] wo [3];
  logic [15:0] wx [3];
  logic [15:0] wy [3];
  logic [1:0]  a_x, a_y, c_x, c_y;
  logic [2:0]  b_x, b_y;

  always #5 clk = ~clk;

  pixel_window_gen #(.WIDTH(4), .DEPTH(4)) u_a (
    .clk(clk), .rst_n(rst_n), .pix_in(pi[0]), .pix_valid(pv[0]), .pix_ready(pr[0]),
    .win_out(wo[0]), .win_x(a_x), .win_y(a_y), .win_valid(wv[0]), .win_ready(wr[0]),
    .frame_done(fd[0])
  );
  pixel_window_gen #(.WIDTH(6), .DEPTH(5)) u_b (
    .clk(clk), .rst_n(rst_n), .pix_in(pi[1]), .pix_valid(pv[1]), .pix_ready(pr[1]),
    .win_out(wo[1]), .win_x(b_x), .win_y(b_y), .win_valid(wv[1]), .win_ready(wr[1]),
    .frame_done(fd[1])
  );
  pixel_window_gen #(.WIDTH(3), .DEPTH(3)) u_c (
    .clk(clk), .rst_n(rst_n), .pix_in(pi[2]), .pix_valid(pv[2]), .pix_ready(pr[2]),
    .win_out(wo[2]), .win_x(c_x), .win_y(c_y), .win_valid(wv[2]), .win_ready(wr[2]),
    .frame_done(fd[2])
  );

  assign wx[0] = {14'd0, a_x};
  assign wy[0] = {14'd0, a_y};
  assign wx[1] = {13'd0, b_x};
  assign wy[1] = {13'd0, b_y};
  assign wx[2] = {14'd0, c_x};
  assign wy[2] = {14'd0, c_y};

  int         tests = 0;
  int         fails = 0;
  int         sel   = 0;
  int         w_img = 4;
  int         d_img = 4;
  int         mx = 0, my = 0;
  int         pops = 0, frames = 0;
  logic       wv_m = 1'b0;
  logic       fd_m = 1'b0;
  logic [7:0] img [8][8];
  exp_t       sb [$];

  task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [71:0] exp_win(input int px, input int py);
    logic [71:0] w;
    w = '0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        w[8*(3*r+c) +: 8] = img[py-2+r][px-2+c];
    return w;
  endfunction

  // One clock: sample at negedge, update the reference model, return #1 after posedge.
  task automatic cycle();
    logic acc, emit, last;
    exp_t e;
    @(negedge clk);
    check("win_valid", 72'(wv[sel]), 72'(wv_m));
    check("frame_done", 72'(fd[sel]), 72'(fd_m));
    if (wv[sel] && wr[sel]) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $error("FAIL unexpected_window: observed x=%0d y=%0d expected none", wx[sel], wy[sel]);
      end else begin
        e = sb.pop_front();
        pops++;
        check("win_out", wo[sel], e.w);
        check("win_x", 72'(wx[sel]), 72'(e.x));
        check("win_y", 72'(wy[sel]), 72'(e.y));
      end
    end
    acc  = pv[sel] && pr[sel];
    emit = acc && mx >= 2 && my >= 2;
    last = acc && mx == w_img - 1 && my == d_img - 1;
    if (emit) begin
      e.w = exp_win(mx, my);
      e.x = mx - 1;
      e.y = my - 1;
      sb.push_back(e);
    end
    wv_m = emit ? 1'b1 : (wr[sel] ? 1'b0 : wv_m);
    fd_m = last;
    if (acc) begin
      if (mx == w_img - 1) begin
        mx = 0;
        if (my == d_img - 1) begin
          my = 0;
          frames++;
        end else my++;
      end else mx++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input bit random_mode);
    int f0 = frames;
    int n  = 0;
    while (frames == f0 && n < 3000) begin
      pv[sel] = random_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
      wr[sel] = random_mode ? ($urandom_range(0, 2) != 0) : 1'b1;
      pi[sel] = img[my][mx];
      cycle();
      n++;
    end
    if (frames == f0) begin
      tests++;
      fails++;
      $error("FAIL frame_timeout: observed %0d cycles expected frame end", n);
    end
  endtask

  task automatic drain();
    pv[sel] = 1'b0;
    wr[sel] = 1'b1;
    for (int n = 0; n < 4; n++) cycle();
    check("drain_empty", 72'(sb.size()), 72'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int p0, n;
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      pv[i] = 1'b0;
      pi[i] = '0;
      wr[i] = 1'b1;
    end
    for (int yy = 0; yy < 8; yy++)
      for (int xx = 0; xx < 8; xx++)
        img[yy][xx] = 8'(16 * yy + xx);
    #12;
    check("rst_win_valid", 72'(wv[0]), 72'(0));
    check("rst_frame_done", 72'(fd[0]), 72'(0));
    check("rst_win_out", wo[0], 72'(0));
    check("rst_win_xy", 72'({wx[0], wy[0]}), 72'(0));
    check("rst_pix_ready", 72'(pr[0]), 72'(1));
    #5 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 4x4 continuous: two back-to-back frames give identical windows.
    sel = 0; w_img = 4; d_img = 4;
    p0 = pops;
    run_frame(1'b0);
    drain();
    check("win_count_f1", 72'(pops - p0), 72'(4));
    p0 = pops;
    run_frame(1'b0);
    drain();
    check("win_count_f2", 72'(pops - p0), 72'(4));

    // Backpressure on the first window for five cycles.
    p0 = pops;
    wr[0] = 1'b0;
    pv[0] = 1'b1;
    n = 0;
    while (!wv[0] && n < 40) begin
      pi[0] = img[my][mx];
      cycle();
      n++;
    end
    check("bp_window_seen", 72'(wv[0]), 72'(1));
    for (int k = 0; k < 5; k++) begin
      pi[0] = img[my][mx];
      cycle();
      check("bp_pix_ready", 72'(pr[0]), 72'(0));
      if (sb.size() > 0) begin
        check("bp_hold_win", wo[0], sb[0].w);
        check("bp_hold_x", 72'(wx[0]), 72'(sb[0].x));
        check("bp_hold_y", 72'(wy[0]), 72'(sb[0].y));
      end
    end
    run_frame(1'b0);
    drain();
    check("win_count_bp", 72'(pops - p0), 72'(4));

    // Asynchronous reset in the middle of row 2.
    wr[0] = 1'b1;
    pv[0] = 1'b1;
    n = 0;
    while (!(my == 2 && mx == 1) && n < 40) begin
      pi[0] = img[my][mx];
      cycle();
      n++;
    end
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_win_valid", 72'(wv[0]), 72'(0));
    check("mid_rst_win_out", wo[0], 72'(0));
    check("mid_rst_win_xy", 72'({wx[0], wy[0]}), 72'(0));
    check("mid_rst_frame_done", 72'(fd[0]), 72'(0));
    sb.delete();
    mx = 0; my = 0; wv_m = 1'b0; fd_m = 1'b0;
    pv[0] = 1'b0;
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    p0 = pops;
    run_frame(1'b0);
    drain();
    check("win_count_post_rst", 72'(pops - p0), 72'(4));

    // 6x5 random image with random input gaps and output stalls.
    sel = 1; w_img = 6; d_img = 5; mx = 0; my = 0;
    for (int yy = 0; yy < 8; yy++)
      for (int xx = 0; xx < 8; xx++)
        img[yy][xx] = 8'($urandom_range(0, 255));
    p0 = pops;
    run_frame(1'b1);
    drain();
    check("win_count_rand", 72'(pops - p0), 72'(12));

    // Minimum 3x3 image: one window holding all nine pixels.
    sel = 2; w_img = 3; d_img = 3; mx = 0; my = 0;
    for (int yy = 0; yy < 3; yy++)
      for (int xx = 0; xx < 3; xx++)
        img[yy][xx] = 8'(8'hA0 + 3 * yy + xx);
    p0 = pops;
    run_frame(1'b0);
    drain();
    check("win_count_min", 72'(pops - p0), 72'(1));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
